// File: rtl/cv32e40p_tmr_fault_monitor_if.sv
// Bus bundle between a TMR stage's three replica outputs, the fault
// monitor and the resync controller/scrubber.
`timescale 1ns/1ps
interface cv32e40p_tmr_fault_monitor_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 valid_i;
  logic [WIDTH-1:0]     res1_i;
  logic [WIDTH-1:0]     res2_i;
  logic [WIDTH-1:0]     res3_i;
  logic [WIDTH-1:0]     voted_o;
  logic                 voted_valid_o;
  logic [2:0]           mismatch_o;
  logic [2:0]           fault_o;
  logic                 uncorrectable_o;
  logic                 resync_req_o;
  logic [1:0]           resync_id_o;
  logic                 resync_ack_i;
  logic [CNT_WIDTH-1:0] err_cnt_o;

  // Replica source + resync controller side
  modport master (
    output valid_i, res1_i, res2_i, res3_i, resync_ack_i,
    input  voted_o, voted_valid_o, mismatch_o, fault_o, uncorrectable_o,
           resync_req_o, resync_id_o, err_cnt_o
  );

  // Monitor side
  modport slave (
    input  valid_i, res1_i, res2_i, res3_i, resync_ack_i,
    output voted_o, voted_valid_o, mismatch_o, fault_o, uncorrectable_o,
           resync_req_o, resync_id_o, err_cnt_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR fault monitor: registers the 2-of-3 vote, flags disagreeing replicas,
// tracks persistent faults per replica and drives a resync req/ack handshake.
// A replica still wrong inside the post-resync window is marked faulty.
`timescale 1ns/1ps

// Per-replica disagreement detect and saturating persistence counter.
module cv32e40p_tmr_fault_monitor_lane #(
  parameter int WIDTH          = 32,
  parameter int PERSIST_CYCLES = 4,
  parameter int PC_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] res,
  input  logic [WIDTH-1:0] maj,
  input  logic             fault,
  input  logic             clr,
  output logic             mm,
  output logic             persist
);
  logic [PC_W-1:0] pc_q, pc_d;

  assign mm      = |(res ^ maj);
  assign persist = (pc_q == PC_W'(PERSIST_CYCLES)) & ~fault;

  // Count consecutive valid mismatches; a faulty replica is parked at 0,
  // and a completed resync restarts it.
  always_comb begin
    pc_d = pc_q;
    if (fault || clr)
      pc_d = '0;
    else if (valid)
      pc_d = !mm ? '0 :
             (pc_q == PC_W'(PERSIST_CYCLES)) ? pc_q : pc_q + PC_W'(1);
  end

  // Persistence counter register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end
endmodule

module cv32e40p_tmr_fault_monitor #(
  parameter int WIDTH          = 32,
  parameter int PERSIST_CYCLES = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  cv32e40p_tmr_fault_monitor_if.slave    bus
);
  localparam int PC_W = $clog2(PERSIST_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHECK} state_e;

  state_e               state_q, state_d;
  logic [1:0]           id_q, id_d;
  logic [PC_W-1:0]      win_q, win_d;
  logic [2:0]           fault_q, fault_d;
  logic [WIDTH-1:0]     voted_q, voted_d;
  logic                 voted_valid_q, voted_valid_d;
  logic [2:0]           mismatch_q, mismatch_d;
  logic                 unc_q, unc_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [2:0][WIDTH-1:0] res;
  logic [WIDTH-1:0]      maj;
  logic [2:0]            mm, persist;
  logic                  ack_take;

  assign res      = {bus.res3_i, bus.res2_i, bus.res1_i};
  assign maj      = (res[0] & res[1]) | (res[0] & res[2]) | (res[1] & res[2]);
  assign ack_take = (state_q == S_REQ) & bus.resync_ack_i;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    cv32e40p_tmr_fault_monitor_lane #(
      .WIDTH(WIDTH), .PERSIST_CYCLES(PERSIST_CYCLES), .PC_W(PC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .valid  (bus.valid_i),
      .res    (res[k]),
      .maj    (maj),
      .fault  (fault_q[k]),
      .clr    (ack_take & (id_q == 2'(k))),
      .mm     (mm[k]),
      .persist(persist[k])
    );
  end

  // Vote/mismatch capture, error event counter and uncorrectable flag
  always_comb begin
    voted_d       = voted_q;
    voted_valid_d = bus.valid_i;
    mismatch_d    = '0;
    err_cnt_d     = err_cnt_q;
    unc_d         = unc_q;
    if (bus.valid_i) begin
      voted_d    = maj;
      mismatch_d = mm;
      if (|mm && err_cnt_q != '1)
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      if ((mm[0] & mm[1]) | (mm[0] & mm[2]) | (mm[1] & mm[2]))
        unc_d = 1'b1;
    end
  end

  // Resync FSM: pick lowest persistent replica, handshake, then watch it
  // for a clean window before trusting it again.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    win_d   = win_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (|persist) begin
          state_d = S_REQ;
          id_d    = persist[0] ? 2'd0 : persist[1] ? 2'd1 : 2'd2;
        end
      end
      S_REQ: begin
        if (bus.resync_ack_i) begin
          state_d = S_CHECK;
          win_d   = '0;
        end
      end
      S_CHECK: begin
        if (bus.valid_i) begin
          if (mm[id_q]) begin
            fault_d[id_q] = 1'b1;
            state_d       = S_IDLE;
          end else begin
            win_d = win_q + PC_W'(1);
            if (win_q == PC_W'(PERSIST_CYCLES - 1))
              state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any request in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      id_q          <= '0;
      win_q         <= '0;
      fault_q       <= '0;
      voted_q       <= '0;
      voted_valid_q <= 1'b0;
      mismatch_q    <= '0;
      unc_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      win_q         <= win_d;
      fault_q       <= fault_d;
      voted_q       <= voted_d;
      voted_valid_q <= voted_valid_d;
      mismatch_q    <= mismatch_d;
      unc_q         <= unc_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.voted_o         = voted_q;
  assign bus.voted_valid_o   = voted_valid_q;
  assign bus.mismatch_o      = mismatch_q;
  assign bus.fault_o         = fault_q;
  assign bus.uncorrectable_o = unc_q;
  assign bus.resync_req_o    = (state_q == S_REQ);
  assign bus.resync_id_o     = id_q;
  assign bus.err_cnt_o       = err_cnt_q;
endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Bench for the TMR fault monitor: directed scenarios plus a random phase,
// all checked every cycle against a behavioural model of the monitor.
`timescale 1ns/1ps
module tb_cv32e40p_tmr_fault_monitor;
  localparam int WIDTH   = 32;
  localparam int P       = 4;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40p_tmr_fault_monitor_if #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) bus ();

  cv32e40p_tmr_fault_monitor #(
    .WIDTH(WIDTH), .PERSIST_CYCLES(P), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: expected outputs plus a replica-level view of resync progress
  logic [31:0] e_voted;
  bit          e_vv, e_unc;
  bit   [2:0]  e_mm, e_fault;
  int          e_cnt, e_id;
  int          m_pc [3];
  int          m_target;     // replica under resync, -1 when none
  bit          m_requesting; // waiting for ack
  int          m_clean;      // clean valid samples since ack

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_voted = '0; e_vv = 0; e_unc = 0; e_mm = '0; e_fault = '0;
    e_cnt = 0; e_id = 0; m_target = -1; m_requesting = 0; m_clean = 0;
    for (int k = 0; k < 3; k++) m_pc[k] = 0;
  endtask

  task automatic model_step();
    logic [31:0] r [3];
    logic [31:0] maj;
    bit   [2:0]  mm, pers;
    int          ones;
    if (rst) begin
      model_reset();
      return;
    end
    r[0] = bus.res1_i; r[1] = bus.res2_i; r[2] = bus.res3_i;
    for (int b = 0; b < 32; b++) begin
      ones = 0;
      for (int k = 0; k < 3; k++) ones += int'(r[k][b]);
      maj[b] = (ones >= 2);
    end
    for (int k = 0; k < 3; k++) begin
      mm[k]   = (r[k] != maj);
      pers[k] = (m_pc[k] == P) && !e_fault[k];
    end
    for (int k = 0; k < 3; k++) begin
      if (e_fault[k]) m_pc[k] = 0;
      else if (bus.valid_i) m_pc[k] = mm[k] ? ((m_pc[k] < P) ? m_pc[k] + 1 : P) : 0;
    end
    if (bus.valid_i) begin
      e_voted = maj; e_vv = 1; e_mm = mm;
      if (mm != 0 && e_cnt < CNT_MAX) e_cnt++;
      if ($countones(mm) >= 2) e_unc = 1;
    end else begin
      e_vv = 0; e_mm = '0;
    end
    if (m_target < 0) begin
      for (int k = 2; k >= 0; k--) if (pers[k]) m_target = k;
      if (m_target >= 0) begin m_requesting = 1; e_id = m_target; end
    end else if (m_requesting) begin
      if (bus.resync_ack_i) begin
        m_pc[m_target] = 0; m_requesting = 0; m_clean = 0;
      end
    end else if (bus.valid_i) begin
      if (mm[m_target]) begin
        e_fault[m_target] = 1; m_target = -1;
      end else begin
        m_clean++;
        if (m_clean == P) m_target = -1;
      end
    end
  endtask

  task automatic check_all();
    chk("voted_o",         64'(bus.voted_o),         64'(e_voted));
    chk("voted_valid_o",   64'(bus.voted_valid_o),   64'(e_vv));
    chk("mismatch_o",      64'(bus.mismatch_o),      64'(e_mm));
    chk("fault_o",         64'(bus.fault_o),         64'(e_fault));
    chk("uncorrectable_o", 64'(bus.uncorrectable_o), 64'(e_unc));
    chk("resync_req_o",    64'(bus.resync_req_o),    64'(m_requesting));
    chk("resync_id_o",     64'(bus.resync_id_o),     64'(e_id));
    chk("err_cnt_o",       64'(bus.err_cnt_o),       64'(e_cnt));
  endtask

  // One clock: model consumes the same inputs as the DUT, outputs compared mid-cycle
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input bit ack);
    bus.valid_i = v; bus.res1_i = a; bus.res2_i = b; bus.res3_i = c;
    bus.resync_ack_i = ack;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.resync_req_o && n < 20) begin cyc(); n++; end
    chk("req_wait_bound", 64'(bus.resync_req_o), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, '0, '0, 0);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  localparam logic [31:0] A5 = 32'hA5A5_A5A5;
  localparam logic [31:0] A4 = 32'hA5A5_A5A4;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, rv [3];
    int bad;
    model_reset();
    do_reset();
    chk("reset_voted",  64'(bus.voted_o), 64'd0);
    chk("reset_req",    64'(bus.resync_req_o), 64'd0);
    chk("reset_errcnt", 64'(bus.err_cnt_o), 64'd0);

    // Clean vote
    drive(1, A5, A5, A5, 0); cyc();
    chk("clean_voted", 64'(bus.voted_o), 64'(A5));
    chk("clean_vv",    64'(bus.voted_valid_o), 64'd1);
    chk("clean_mm",    64'(bus.mismatch_o), 64'd0);
    chk("clean_cnt",   64'(bus.err_cnt_o), 64'd0);

    // Replica 1 persistently wrong, slow ack, then a clean check window
    drive(1, A5, A4, A5, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("r1_voted", 64'(bus.voted_o), 64'(A5));
      chk("r1_mm",    64'(bus.mismatch_o), 64'b010);
    end
    chk("r1_cnt4", 64'(bus.err_cnt_o), 64'd4);
    drive(0, A5, A5, A5, 0); cyc();
    chk("r1_req", 64'(bus.resync_req_o), 64'd1);
    chk("r1_id",  64'(bus.resync_id_o), 64'd1);
    chk("r1_cnt", 64'(bus.err_cnt_o), 64'd4);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("r1_req_hold", 64'(bus.resync_req_o), 64'd1);
      chk("r1_id_hold",  64'(bus.resync_id_o), 64'd1);
    end
    drive(0, A5, A5, A5, 1); cyc();
    chk("r1_req_drop", 64'(bus.resync_req_o), 64'd0);
    drive(1, A5, A5, A5, 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("r1_fault_clean", 64'(bus.fault_o), 64'd0);
    chk("r1_req_idle",    64'(bus.resync_req_o), 64'd0);

    // Replica 1 fails again right after resync -> faulty
    drive(1, A5, A4, A5, 0);
    for (int i = 0; i < 4; i++) cyc();
    drive(0, A5, A5, A5, 0); wait_req();
    drive(0, A5, A5, A5, 1); cyc();
    drive(1, A5, A5, A5, 0); cyc();
    drive(1, A5, A4, A5, 0); cyc();
    chk("r1_fault_set", 64'(bus.fault_o), 64'b010);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("r1_no_new_req", 64'(bus.resync_req_o), 64'd0);
    end

    // Two replicas disagree in one sample
    drive(1, 32'h1, 32'h2, 32'h0, 0); cyc();
    chk("unc_voted", 64'(bus.voted_o), 64'd0);
    chk("unc_mm",    64'(bus.mismatch_o), 64'b011);
    chk("unc_set",   64'(bus.uncorrectable_o), 64'd1);
    drive(1, A5, A5, A5, 0);
    for (int i = 0; i < 100; i++) cyc();
    chk("unc_sticky", 64'(bus.uncorrectable_o), 64'd1);

    // Random phase with bursty per-replica corruption and random acks/resets
    do_reset();
    bad = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) bad = $urandom_range(0, 3);
      base = $urandom;
      for (int k = 0; k < 3; k++) begin
        rv[k] = base;
        if ((k == bad) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0))
          rv[k] = base ^ (32'h1 << $urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, rv[0], rv[1], rv[2], $urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 1'b0;

    // Reset while a request is outstanding
    do_reset();
    drive(1, A4, A5, A5, 0);
    for (int i = 0; i < 4; i++) cyc();
    drive(0, A5, A5, A5, 0); wait_req();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_req",   64'(bus.resync_req_o), 64'd0);
    chk("rst_mm",    64'(bus.mismatch_o), 64'd0);
    chk("rst_fault", 64'(bus.fault_o), 64'd0);
    chk("rst_cnt",   64'(bus.err_cnt_o), 64'd0);
    chk("rst_vv",    64'(bus.voted_valid_o), 64'd0);
    chk("rst_voted", 64'(bus.voted_o), 64'd0);
    chk("rst_unc",   64'(bus.uncorrectable_o), 64'd0);
    chk("rst_id",    64'(bus.resync_id_o), 64'd0);

    // Error counter saturation
    drive(1, A5, A5, A4, 0);
    for (int i = 0; i < CNT_MAX + 6; i++) cyc();
    chk("cnt_sat", 64'(bus.err_cnt_o), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
